// File: rtl/data_memory_be.sv
// Byte-addressable data memory for the MEM stage: byte/half/word access, sign/zero extension,
// registered read with ready/valid. Define DMEM_INIT_CLEAR_EN to zero the array after reset.
module data_memory_be #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_misalign
);

  localparam int WADDR = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** WADDR;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic             clr_we;
  logic [WADDR-1:0] clr_cnt;

`ifdef DMEM_INIT_CLEAR_EN
  typedef enum logic {S_CLEAR, S_IDLE} state_e;
  state_e state, state_nxt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_CLEAR;
      clr_cnt <= '0;
      o_ready <= 1'b0;
    end else begin
      state   <= state_nxt;
      o_ready <= (state_nxt == S_IDLE);
      if (clr_we) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // NOTE: defaults at the top of a combinational block keep every path assigned, so no latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (&clr_cnt) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The clear port is held off while reset is asserted so reset alone never alters contents.
  always_comb begin
    clr_we = (state == S_CLEAR) && !i_rst;
  end
`else
  assign clr_we  = 1'b0;
  assign clr_cnt = '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) o_ready <= 1'b0;
    else       o_ready <= 1'b1;
  end
`endif

  // Request decode: alignment fault, written lanes, and store data replicated onto every lane.
  logic                  accept;
  logic                  fault;
  logic [WADDR-1:0]      widx;
  logic [1:0]            off;
  logic [3:0]            lane_en;
  logic [DATA_WIDTH-1:0] wdata;

  always_comb begin
    accept  = i_req && o_ready && !i_rst;
    widx    = i_addr[ADDR_WIDTH-1:2];
    off     = i_addr[1:0];
    fault   = 1'b0;
    lane_en = 4'b0000;
    wdata   = i_data;
    case (i_size)
      SZ_BYTE: begin
        lane_en = 4'b0001 << off;
        wdata   = {4{i_data[7:0]}};
      end
      SZ_HALF: begin
        fault   = off[0];
        lane_en = 4'b0011 << {off[1], 1'b0};
        wdata   = {2{i_data[15:0]}};
      end
      SZ_WORD: begin
        fault   = (off != 2'b00);
        lane_en = 4'b1111;
      end
      default: fault = 1'b1;
    endcase
  end

  // NOTE: the array has no reset; clearing it is the sequencer's job, not the reset network's.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= '0;
    end else if (accept && i_we && !fault) begin
      for (int k = 0; k < 4; k++)
        if (lane_en[k]) mem[widx][8*k +: 8] <= wdata[8*k +: 8];
    end
  end

  logic [DATA_WIDTH-1:0] rd_word;
  logic [1:0]            r_size;
  logic [1:0]            r_off;
  logic                  r_uns;
  logic                  r_load;

  always_ff @(posedge i_clk) begin
    if (accept && !i_we) begin
      rd_word <= mem[widx];
      r_size  <= i_size;
      r_off   <= off;
      r_uns   <= i_unsigned;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid    <= 1'b0;
      o_misalign <= 1'b0;
      r_load     <= 1'b0;
    end else begin
      o_valid    <= accept;
      o_misalign <= accept && fault;
      r_load     <= accept && !i_we && !fault;
    end
  end

  // Extension happens after the read register; stores and faults force the result to zero.
  always_comb begin
    logic [7:0]            sel_b;
    logic [15:0]           sel_h;
    logic [DATA_WIDTH-1:0] ext;
    sel_b = rd_word[8*r_off +: 8];
    sel_h = rd_word[16*r_off[1] +: 16];
    case (r_size)
      SZ_BYTE: ext = {{24{sel_b[7] & ~r_uns}}, sel_b};
      SZ_HALF: ext = {{16{sel_h[15] & ~r_uns}}, sel_h};
      default: ext = rd_word;
    endcase
    o_data = r_load ? ext : '0;
  end

endmodule

// File: tb/tb_data_memory_be.sv
// Self-checking bench for data_memory_be (ADDR_WIDTH=6, 16 words) against a byte-array model.
module tb_data_memory_be;

`ifdef DMEM_INIT_CLEAR_EN
  localparam bit CLR       = 1'b1;
  localparam int READY_LAT = 16;
`else
  localparam bit CLR       = 1'b0;
  localparam int READY_LAT = 1;
`endif

  logic        i_clk;
  logic        i_rst;
  logic        i_req;
  logic        i_we;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic [5:0]  i_addr;
  logic [31:0] i_data;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_data;
  logic        o_misalign;

  data_memory_be #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we), .i_size(i_size),
    .i_unsigned(i_unsigned), .i_addr(i_addr), .i_data(i_data), .o_ready(o_ready),
    .o_valid(o_valid), .o_data(o_data), .o_misalign(o_misalign)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  // Reference model: one entry per byte address, little-endian.
  logic [7:0] mem_m [64];

  logic        exp_valid = 1'b0;
  logic        exp_mis   = 1'b0;
  logic [31:0] exp_data  = '0;
  string       exp_tag   = "none";

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit model_fault(input logic [1:0] size, input int addr);
    if (size == 2'b11) return 1'b1;
    return (addr % (1 << size)) != 0;
  endfunction

  task automatic model_store(input logic [1:0] size, input int addr, input logic [31:0] data);
    for (int b = 0; b < (1 << size); b++) mem_m[addr + b] = data[8*b +: 8];
  endtask

  function automatic logic [31:0] model_load(input logic [1:0] size, input bit uns, input int addr);
    longint v = 0;
    int     n = 1 << size;
    for (int b = 0; b < n; b++) v += longint'(mem_m[addr + b]) << (8 * b);
    if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) mem_m[i] = 8'h00;
  endtask

  task automatic check_pending();
    chk({exp_tag, ".valid"}, 32'(o_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk({exp_tag, ".misalign"}, 32'(o_misalign), 32'(exp_mis));
      chk({exp_tag, ".data"}, o_data, exp_data);
    end
  endtask

  // One cycle: check the previous cycle's result, then drive (or not) a new access.
  task automatic step(input string tag, input bit req, input bit we, input logic [1:0] size,
                      input bit uns, input int addr, input logic [31:0] data,
                      input bit use_want, input logic [31:0] want);
    check_pending();
    if (req) chk({tag, ".ready"}, 32'(o_ready), 32'd1);
    i_req      = req;
    i_we       = we;
    i_size     = size;
    i_unsigned = uns;
    i_addr     = 6'(addr);
    i_data     = data;
    exp_tag    = tag;
    exp_valid  = req;
    exp_mis    = req && model_fault(size, addr);
    exp_data   = '0;
    if (req && !exp_mis) begin
      if (we) model_store(size, addr, data);
      else    exp_data = use_want ? want : model_load(size, uns, addr);
    end
    @(negedge i_clk);
    i_req = 1'b0;
  endtask

  task automatic st(input string tag, input logic [1:0] size, input int addr, input logic [31:0] data);
    step(tag, 1'b1, 1'b1, size, 1'b0, addr, data, 1'b0, '0);
  endtask

  task automatic ld(input string tag, input logic [1:0] size, input bit uns, input int addr);
    step(tag, 1'b1, 1'b0, size, uns, addr, '0, 1'b0, '0);
  endtask

  task automatic ldw(input string tag, input logic [1:0] size, input bit uns, input int addr,
                     input logic [31:0] want);
    step(tag, 1'b1, 1'b0, size, uns, addr, '0, 1'b1, want);
  endtask

  task automatic idle();
    step("idle", 1'b0, 1'b0, 2'b00, 1'b0, 0, '0, 1'b0, '0);
  endtask

  task automatic fill();
    for (int w = 0; w < 16; w++) st("fill", 2'b10, w * 4, $urandom);
    idle();
  endtask

  // Releases reset and counts edges until o_ready rises (bounded).
  task automatic wait_ready(input string tag);
    int n = 0;
    i_rst = 1'b0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_ready && n < 100);
    chk(tag, n, READY_LAT);
  endtask

  initial begin
    bit          rq;
    logic [1:0]  sz;
    int          a;

    i_rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_size = 2'b00;
    i_unsigned = 1'b0; i_addr = '0; i_data = '0;
    model_clear();

    repeat (2) @(negedge i_clk);
    chk("rst.ready", 32'(o_ready), 32'd0);
    chk("rst.valid", 32'(o_valid), 32'd0);
    chk("rst.data", o_data, 32'd0);
    chk("rst.misalign", 32'(o_misalign), 32'd0);
    wait_ready("rst.latency");

    // Contents across a reset pulse: cleared with the sequencer, preserved without it.
    fill();
    st("pre.sw", 2'b10, 'h08, 32'hDEADBEEF);
    idle();
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    wait_ready("clr.latency");
    if (CLR) model_clear();
    ldw("clr.lw", 2'b10, 1'b0, 'h08, CLR ? 32'h0 : 32'hDEADBEEF);
    fill();

    // Byte lanes
    st("bl.sw", 2'b10, 'h10, 32'h11223344);
    st("bl.sb", 2'b00, 'h12, 32'h000000AB);
    ldw("bl.lw", 2'b10, 1'b0, 'h10, 32'h11AB3344);
    ldw("bl.lb", 2'b00, 1'b0, 'h12, 32'hFFFFFFAB);
    ldw("bl.lbu", 2'b00, 1'b1, 'h12, 32'h000000AB);

    // Halves
    st("hw.sh", 2'b01, 'h16, 32'h00008001);
    ldw("hw.lh", 2'b01, 1'b0, 'h16, 32'hFFFF8001);
    ldw("hw.lhu", 2'b01, 1'b1, 'h16, 32'h00008001);
    ld("hw.lw", 2'b10, 1'b0, 'h14);
    ldw("hw.lw_uns", 2'b10, 1'b1, 'h10, 32'h11AB3344);

    // Misaligned and reserved-size accesses
    ld("mis.lw", 2'b10, 1'b0, 'h11);
    st("mis.sh", 2'b01, 'h13, 32'hFFFFFFFF);
    ld("mis.rsv_ld", 2'b11, 1'b0, 'h10);
    st("mis.rsv_st", 2'b11, 'h10, 32'hFFFFFFFF);
    st("mis.sw", 2'b10, 'h12, 32'hFFFFFFFF);
    ldw("mis.lw_after", 2'b10, 1'b0, 'h10, 32'h11AB3344);

    // Back-to-back with i_req held high
    st("b2b.pre", 2'b10, 'h24, 32'h0BADF00D);
    idle();
    st("b2b.sw", 2'b10, 'h20, 32'd5);
    ldw("b2b.lw20", 2'b10, 1'b0, 'h20, 32'd5);
    ldw("b2b.lw24", 2'b10, 1'b0, 'h24, 32'h0BADF00D);
    idle();
    idle();

    // A request coincident with reset is dropped and produces no completion.
    i_rst = 1'b1; i_req = 1'b1; i_we = 1'b0; i_size = 2'b10; i_addr = 6'h20;
    @(negedge i_clk);
    i_req = 1'b0;
    chk("rstreq.valid", 32'(o_valid), 32'd0);
    chk("rstreq.ready", 32'(o_ready), 32'd0);
    @(negedge i_clk);

    // Reset during the clear sequence restarts it.
    i_rst = 1'b0;
    repeat (7) @(negedge i_clk);
    chk("mid.ready", 32'(o_ready), CLR ? 32'd0 : 32'd1);
    i_rst = 1'b1;
    @(negedge i_clk);
    wait_ready("mid.latency");
    if (CLR) model_clear();
    exp_valid = 1'b0;
    ld("mid.lw20", 2'b10, 1'b0, 'h20);
    ld("mid.lw08", 2'b10, 1'b0, 'h08);
    fill();

    // Randomised traffic against the model
    for (int i = 0; i < 300; i++) begin
      rq = ($urandom_range(0, 9) < 8);
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = $urandom_range(0, 63);
      if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a - (a % (1 << sz));
      step("rand", rq, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
           1'b0, '0);
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_be.md
# data_memory_be

Parametrised byte-addressable data memory for the pipelined MIPS core's MEM stage, replacing the word-only data memory. Supports byte, halfword and word loads/stores with sign or zero extension, a registered one-cycle read path with valid/ready handshake, and alignment checking. An optional reset-time clear sequencer zeroes the whole array before the first access.

## Interface
- DATA_WIDTH, 32, word width in bits; fixed at 32 (four byte lanes).
- ADDR_WIDTH, 10, byte-address width; DEPTH = 2^(ADDR_WIDTH-2) words (256 by default).

- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_req  input  1  access request; accepted when i_req && o_ready.
- i_we  input  1  1 = store, 0 = load.
- i_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- i_unsigned  input  1  load extension: 1 zero-extend, 0 sign-extend (lbu/lhu vs lb/lh).
- i_addr  input  ADDR_WIDTH  byte address.
- i_data  input  DATA_WIDTH  store data, right-justified (byte in [7:0], half in [15:0]).
- o_ready  output  1  block can accept an access this cycle.
- o_valid  output  1  one-cycle pulse completing the previously accepted access.
- o_data  output  DATA_WIDTH  extended load result; 0 for stores and faulted accesses.
- o_misalign  output  1  qualified by o_valid; accepted access was misaligned or reserved size.

## Operation
- Little-endian: word index = i_addr[ADDR_WIDTH-1:2]; lane k = bits [8k+7:8k], k = i_addr[1:0] for bytes, i_addr[1]*2 for halves.
- Fault: i_size=11; half with i_addr[0]=1; word with i_addr[1:0]!=00. Faulted store writes nothing; faulted load returns 0. Both raise o_misalign with o_valid.
- Store: only the addressed lanes are written (1, 2 or 4 lanes); other bytes of the word are preserved.
- Load: selected byte/half is shifted to bit 0, bits above are filled with its MSB (signed) or 0 (unsigned). Word loads ignore i_unsigned.
- FSM: CLEAR -> IDLE. In CLEAR a word counter writes 0 to word 0..DEPTH-1, one per cycle; o_ready=0; requests are ignored (not queued). After word DEPTH-1 goes to IDLE. IDLE: o_ready=1, one access per cycle, fully back-to-back.
- Reset in any state (including mid-CLEAR) restarts the FSM: counter to 0, any in-flight o_valid cancelled.
- Reset values: o_ready=0, o_valid=0, o_data=0, o_misalign=0. Array contents are not modified by reset itself.

## Timing
- Accept at edge N -> o_valid, o_data, o_misalign valid in cycle N+1 (registered), deasserted in N+2 unless another access was accepted at N+1.
- Store accepted at N updates the array at edge N; a load accepted at N+1 to the same address returns the new data at N+2 (no hazard).
- Single port: one access per cycle; i_we selects read or write, no simultaneous read+write.
- o_ready is registered from the FSM state; it does not depend combinationally on i_req.
- Clear duration: DEPTH cycles after the cycle i_rst deasserts; o_ready first high in cycle DEPTH+1.

## Configuration
- DMEM_INIT_CLEAR_EN defined: reset enters CLEAR as above; all words read 0 afterwards.
- Not defined: no CLEAR state or counter; reset goes directly to IDLE, o_ready=1 in the first cycle after i_rst deasserts; contents hold their initial/previous values (X in simulation if never written).

## Test plan
- Reset + clear (macro on, ADDR_WIDTH=6, DEPTH=16): pre-write 0xDEADBEEF at 0x08, pulse i_rst -> o_ready low 16 cycles, then lw 0x08 -> 0x00000000.
- Byte lanes: sw 0x11223344 @0x10; sb 0xAB @0x12 -> lw 0x10 = 0x11AB3344; lb @0x12 = 0xFFFFFFAB; lbu @0x12 = 0x000000AB.
- Halves: sh 0x8001 @0x16 -> lh @0x16 = 0xFFFF8001, lhu = 0x00008001, lw 0x14 = 0x8001xxxx with low half unchanged.
- Misalign: lw @0x11, sh @0x13, i_size=11 @0x10 -> o_valid with o_misalign=1, o_data=0; lw 0x10 shows no change.
- Back-to-back: i_req held high with sw @0x20=5, lw @0x20, lw @0x24 -> o_valid high 3 consecutive cycles, loads return 5 then stored value at 0x24.
- Reset mid-clear: assert i_rst at clear cycle 7 -> clear restarts, o_ready high exactly DEPTH cycles after the second deassert; with macro off o_ready high the cycle after deassert.
